timer_ctrl: RTL
===============

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100: clk cycles per count tick, legal range 2..65535.
REQ-002 SHALL have parameter DB_CYCLES, default 50000: consecutive stable cycles required to accept a button level, legal range 1..65535.
REQ-003 SHALL have parameter MAX_COUNT, default 9999: terminal count, legal range 1..9999.
REQ-004 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port btn_start, input, 1: raw asynchronous start/stop button, active high.
REQ-007 SHALL have port btn_clear, input, 1: raw asynchronous clear button, active high.
REQ-008 SHALL have port tick_o, output, 1: one-cycle enable pulse that advances the display timer.
REQ-009 SHALL have port clear_o, output, 1: one-cycle pulse that zeroes the display timer.
REQ-010 SHALL have port count_o, output, 14: binary count of ticks issued since the last clear.
REQ-011 SHALL have port state_o, output, 2: current state, IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-013 SHALL debounce each synchronized button independently: the debounced level takes the synchronized value only after that value differs from the debounced level for DB_CYCLES consecutive cycles; any mismatch gap restarts the count.
REQ-014 SHALL generate an internal one-cycle press event on each 0->1 transition of a debounced level; a release generates no event.
REQ-015 SHALL register the state change for a press on the edge after the debounced level rises, giving DB_CYCLES+3 edges from the first edge that samples raw high to the new state_o.
REQ-016 SHALL move IDLE->RUN on start press, with the prescaler at 0.
REQ-017 SHALL, in RUN, count the prescaler 0..CLK_DIV-1 and wrap it to 0; tick_o SHALL be 1 in exactly the cycle after the prescaler equals CLK_DIV-1, and count_o SHALL increment on that same edge.
REQ-018 SHALL move RUN->PAUSE on start press, with the prescaler holding its value; PAUSE->RUN on start press SHALL resume from the held value.
REQ-019 SHALL move RUN->DONE on the edge where count_o becomes MAX_COUNT; tick_o SHALL never assert in DONE, and start presses SHALL be ignored in DONE.
REQ-020 SHALL, on clear press in any state, pulse clear_o for 1 cycle, zero count_o and the prescaler, and go to IDLE.
REQ-021 SHALL apply clear precedence when clear and start presses occur in the same cycle: start is discarded.
REQ-022 SHALL, when a start press coincides with a tick-issuing edge in RUN, still issue the tick and increment the count, then enter PAUSE.
REQ-023 SHALL never let count_o exceed MAX_COUNT and never wrap it.
REQ-024 SHALL drive tick_o and clear_o as registered outputs, never high in the same cycle.
REQ-025 SHALL have the instantiating wrapper AND tick_o with the timer's digit-advance enable and route clear_o to the timer's synchronous clear.

Reset
REQ-026 SHALL, while rst_n=0, immediately force state_o=00, tick_o=0, clear_o=0, count_o=0, prescaler=0, synchronizers=0, debounced levels=0 and debounce counters=0.
REQ-027 SHALL sample no press during reset; a button held through reset release SHALL generate a press only after the full debounce interval.
REQ-028 SHALL, on reset assertion mid-RUN, truncate any tick_o pulse in progress and resume in IDLE after release.

Verification (CLK_DIV=4, DB_CYCLES=3, MAX_COUNT=5)
REQ-029 SHALL be verified for basic run: btn_start high 10 cycles -> state_o=01 at edge 6; first tick_o 4 cycles later, then every 4 cycles; count_o 1,2,3...
REQ-030 SHALL be verified for bounce rejection: btn_start toggling every 2 cycles for 20 cycles -> state_o stays 00 and tick_o stays 0.
REQ-031 SHALL be verified for pause/resume: press start after 2 ticks -> state_o=10 with count_o=2 frozen; press again -> remaining prescaler phase honored and count_o=3 after the held remainder.
REQ-032 SHALL be verified for terminal count: run uninterrupted -> count_o=5 and state_o=11; further start presses leave count_o=5 with no tick_o.
REQ-033 SHALL be verified for simultaneous press: start and clear both pressed in RUN at count_o=3 -> one clear_o pulse, count_o=0, state_o=00.
REQ-034 SHALL be verified for reset mid-run: rst_n low for 1 cycle at count_o=4 -> all outputs 0 immediately; after release state_o=00 until a new start press.

Source files
------------

// File: rtl/timer_ctrl.sv
// Start/stop/clear sequencer for a display timer: debounced buttons drive a
// prescaled tick generator with pause, terminal count and clear.
module timer_ctrl #(
  parameter int CLK_DIV   = 100,
  parameter int DB_CYCLES = 50000,
  parameter int MAX_COUNT = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_clear,
  output logic        tick_o,
  output logic        clear_o,
  output logic [13:0] count_o,
  output logic [1:0]  state_o
);

  // state | meaning
  // IDLE  | cleared, waiting for start
  // RUN   | prescaler running, ticks issued
  // PAUSE | prescaler and count frozen
  // DONE  | terminal count reached, only clear leaves
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] DB_LAST  = 16'(DB_CYCLES - 1);
  localparam logic [13:0] MAX_CNT  = 14'(MAX_COUNT);

  logic [1:0]  btn_raw;
  logic [1:0]  sync1, sync2, db_lvl, db_prev;
  logic [15:0] db_cnt [2];
  logic        start_press, clr_press;

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [13:0] count_q, count_d;
  logic        tick_q, tick_d, clear_q, clear_d;

  assign btn_raw = {btn_clear, btn_start};

  // Index 0 is start, index 1 is clear; each debounces independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      db_lvl    <= '0;
      db_prev   <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      db_prev <= db_lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db_lvl[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_lvl[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 16'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign start_press = db_lvl[0] & ~db_prev[0];
  assign clr_press   = db_lvl[1] & ~db_prev[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      clear_q <= clear_d;
    end
  end

  // The edge that enters or leaves PAUSE does not advance the prescaler,
  // unless it is also a tick edge, which is always honoured.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    tick_d  = 1'b0;
    clear_d = 1'b0;
    if (clr_press) begin
      state_d = IDLE;
      presc_d = '0;
      count_d = '0;
      clear_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_press) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (presc_q == DIV_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
            count_d = count_q + 14'd1;
            if (count_d == MAX_CNT)
              state_d = DONE;
            else if (start_press)
              state_d = PAUSE;
          end else if (start_press) begin
            state_d = PAUSE;
          end else begin
            presc_d = presc_q + 16'd1;
          end
        end
        PAUSE: begin
          if (start_press)
            state_d = RUN;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign tick_o  = tick_q;
  assign clear_o = clear_q;
  assign count_o = count_q;
  assign state_o = state_q;

endmodule
